// File: rtl/ws_pkg.sv
// Shared psum types and saturation bounds for the weight-stationary datapath.
// Combinational helpers only; no timing or flow-control behaviour lives here.
package ws_pkg;

  localparam int PSUM_W     = 48;
  localparam int PSUM_MEM_W = 64;

  typedef logic signed [PSUM_W-1:0] psum_t;
  typedef logic [PSUM_MEM_W-1:0]    psum_word_t;

  localparam psum_t PSUM_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
  localparam psum_t PSUM_MIN = {1'b1, {(PSUM_W-1){1'b0}}};

  function automatic psum_word_t psum_sext(input psum_t p);
    return {{(PSUM_MEM_W-PSUM_W){p[PSUM_W-1]}}, p};
  endfunction

endpackage

// File: rtl/psum_sat_add.sv
// psum_sat_add: signed saturating adder, purely combinational (0 cycles).
// No flow control; sat flags a clamp to the most positive/negative value.
module psum_sat_add
  import ws_pkg::*;
#(
  parameter int W = PSUM_W
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                sat
);

  logic signed [W:0] full;

  always_comb begin
    full = {a[W-1], a} + {b[W-1], b};
    sat  = full[W] ^ full[W-1];
    if (!sat)
      sum = full[W-1:0];
    else if (full[W])
      sum = {1'b1, {(W-1){1'b0}}};
    else
      sum = {1'b0, {(W-1){1'b1}}};
  end

endmodule

// File: rtl/psum_accum.sv
// psum_accum: per-row psum read-modify-write accumulator, write 2 cycles after accept, 1 op/cycle.
// No backpressure: in_valid is always taken; RMW hazards are covered by S2/S3 forwarding.
module psum_accum #(
  parameter int ADDR_W = 32,
  parameter int PSUM_W = ws_pkg::PSUM_W,
  parameter int MEM_W  = ws_pkg::PSUM_MEM_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                accum_en,
  input  logic                in_valid,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [PSUM_W-1:0]   in_psum,
  output logic [ADDR_W-1:0]   mem_rd_addr,
  input  logic [MEM_W-1:0]    mem_rd_data,
  output logic [MEM_W/8-1:0]  mem_we,
  output logic [ADDR_W-1:0]   mem_wr_addr,
  output logic [MEM_W-1:0]    mem_wr_data,
  output logic                ovf,
  input  logic                ovf_clr,
  output logic [31:0]         wr_count,
  output logic                idle
);

  // S1: accepted op waiting for its read data
  logic                     s1_vld;
  logic                     s1_accum;
  logic [ADDR_W-1:0]        s1_addr;
  logic signed [PSUM_W-1:0] s1_psum;

  // S2: result being written this cycle
  logic                     s2_vld;
  logic [ADDR_W-1:0]        s2_addr;
  logic [MEM_W-1:0]         s2_data;

  // S3: last cycle's write, landed at the same edge a READ_FIRST read was sampled
  logic                     s3_vld;
  logic [ADDR_W-1:0]        s3_addr;
  logic signed [PSUM_W-1:0] s3_psum;

  logic signed [PSUM_W-1:0] operand;
  logic signed [PSUM_W-1:0] sum;
  logic                     sat;
  logic                     unused_rd_hi;

  assign mem_rd_addr  = in_addr;
  assign unused_rd_hi = ^mem_rd_data[MEM_W-1:PSUM_W];

  always_comb begin
    operand = '0;
    if (!s1_accum)
      operand = '0;
    else if (s2_vld && (s2_addr == s1_addr))
      operand = s2_data[PSUM_W-1:0];
    else if (s3_vld && (s3_addr == s1_addr))
      operand = s3_psum;
    else
      operand = mem_rd_data[PSUM_W-1:0];
  end

  psum_sat_add #(
    .W(PSUM_W)
  ) u_add (
    .a   (s1_psum),
    .b   (operand),
    .sum (sum),
    .sat (sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_accum <= 1'b0;
      s1_addr  <= '0;
      s1_psum  <= '0;
      s2_vld   <= 1'b0;
      s2_addr  <= '0;
      s2_data  <= '0;
      s3_vld   <= 1'b0;
      s3_addr  <= '0;
      s3_psum  <= '0;
      ovf      <= 1'b0;
      wr_count <= '0;
    end else begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_accum <= accum_en;
        s1_addr  <= in_addr;
        s1_psum  <= in_psum;
      end

      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_addr <= s1_addr;
        s2_data <= {{(MEM_W-PSUM_W){sum[PSUM_W-1]}}, sum};
      end

      s3_vld  <= s2_vld;
      s3_addr <= s2_addr;
      s3_psum <= s2_data[PSUM_W-1:0];

      // a saturation landing in the clear cycle keeps the flag set
      if (s1_vld && sat)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;

      if (s2_vld)
        wr_count <= wr_count + 32'd1;
    end
  end

  assign mem_we      = {(MEM_W/8){s2_vld}};
  assign mem_wr_addr = s2_addr;
  assign mem_wr_data = s2_data;
  assign idle        = !(in_valid || s1_vld || s2_vld);

endmodule

// File: tb/tb_psum_accum.sv
// Bench for psum_accum: READ_FIRST 1-cycle memory model, directed vector table plus
// hand-timed sequences for overwrite latency, mid-stream reset and the adder alone.
module tb_psum_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        accum_en = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_addr = '0;
  logic [47:0] in_psum = '0;
  logic [31:0] mem_rd_addr;
  logic [63:0] mem_rd_data;
  logic [7:0]  mem_we;
  logic [31:0] mem_wr_addr;
  logic [63:0] mem_wr_data;
  logic        ovf;
  logic        ovf_clr = 1'b0;
  logic [31:0] wr_count;
  logic        idle;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  psum_accum dut (
    .clk         (clk),
    .rst         (rst),
    .accum_en    (accum_en),
    .in_valid    (in_valid),
    .in_addr     (in_addr),
    .in_psum     (in_psum),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .mem_we      (mem_we),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .ovf         (ovf),
    .ovf_clr     (ovf_clr),
    .wr_count    (wr_count),
    .idle        (idle)
  );

  logic signed [47:0] ua, ub, usum;
  logic               usat;

  psum_sat_add #(.W(48)) u_add (
    .a   (ua),
    .b   (ub),
    .sum (usum),
    .sat (usat)
  );

  // READ_FIRST memory: read samples the old word when a write hits the same edge
  logic [63:0] mem [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_addr = '0;
  logic [63:0] pre_dat = '0;

  always @(posedge clk) begin
    mem_rd_data <= mem[4'(mem_rd_addr)];
    if (mem_we != 8'h00)
      mem[4'(mem_wr_addr)] <= mem_wr_data;
    if (pre_we)
      mem[pre_addr] <= pre_dat;
  end

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic        ovf;
  } wr_t;

  wr_t wq[$];

  always @(negedge clk) begin
    if (mem_we != 8'h00)
      wq.push_back('{mem_wr_addr, mem_wr_data, ovf});
  end

  typedef struct {
    logic        accum;
    logic        clr;
    logic [31:0] addr;
    logic [47:0] psum;
    int          gap;
    logic [63:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_op(input logic acc, input logic clr, input logic [31:0] a, input logic [47:0] p);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    accum_en = acc;
    ovf_clr  = clr;
    in_addr  = a;
    in_psum  = p;
  endtask

  task automatic idle_cyc();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    accum_en = 1'b0;
    ovf_clr  = 1'b0;
  endtask

  initial begin
    logic [63:0]        init_mem [16];
    logic signed [47:0] ta [4];
    logic signed [47:0] tb [4];
    logic signed [47:0] ts [4];
    logic               tsat [4];
    wr_t                w;

    // adder on its own
    ta[0] = 48'sd5;                tb[0] = -48'sd7; ts[0] = -48'sd2;              tsat[0] = 1'b0;
    ta[1] = 48'sh7FFF_FFFF_FFFF;   tb[1] = 48'sd1;  ts[1] = 48'sh7FFF_FFFF_FFFF;  tsat[1] = 1'b1;
    ta[2] = 48'sh8000_0000_0000;   tb[2] = -48'sd1; ts[2] = 48'sh8000_0000_0000;  tsat[2] = 1'b1;
    ta[3] = 48'sh7FFF_FFFF_FFFF;   tb[3] = 48'sh8000_0000_0000; ts[3] = -48'sd1;  tsat[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ua = ta[i];
      ub = tb[i];
      #1;
      chk($sformatf("add_sum[%0d]", i), 64'(usum), 64'(ts[i]));
      chk($sformatf("add_sat[%0d]", i), 64'(usat), 64'(tsat[i]));
    end

    for (int i = 0; i < 16; i++) init_mem[i] = '0;
    init_mem[7] = 64'hFFFF_FFFF_FFFF_FFEC;  // -20
    init_mem[0] = 64'h0000_7FFF_FFFF_FFF6;  // 2^47-10
    init_mem[4] = 64'hFFFF_8000_0000_0005;  // -2^47+5
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      pre_we   = 1'b1;
      pre_addr = 4'(i);
      pre_dat  = init_mem[i];
    end
    @(posedge clk);
    #1;
    pre_we = 1'b0;
    rst    = 1'b0;

    @(negedge clk);
    chk("rst_we", 64'(mem_we), 64'h0);
    chk("rst_wr_addr", 64'(mem_wr_addr), 64'h0);
    chk("rst_wr_data", mem_wr_data, 64'h0);
    chk("rst_ovf", 64'(ovf), 64'h0);
    chk("rst_wr_count", 64'(wr_count), 64'h0);
    chk("rst_idle", 64'(idle), 64'h1);

    // overwrite with exact latency
    drive_op(1'b0, 1'b0, 32'd5, 48'd100);
    @(negedge clk);
    chk("ow_idle_busy", 64'(idle), 64'h0);
    idle_cyc();
    @(negedge clk);
    chk("ow_we_t1", 64'(mem_we), 64'h0);
    idle_cyc();
    @(negedge clk);
    chk("ow_we_t2", 64'(mem_we), 64'hFF);
    chk("ow_addr", 64'(mem_wr_addr), 64'd5);
    chk("ow_data", mem_wr_data, 64'd100);
    idle_cyc();
    @(negedge clk);
    chk("ow_wr_count", 64'(wr_count), 64'd1);
    chk("ow_idle_after", 64'(idle), 64'h1);

    vecs[0]  = '{1'b1, 1'b0, 32'd7, 48'd50, 3, 64'd30, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'd3, 48'd1,  0, 64'd1,  1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'd3, 48'd2,  0, 64'd3,  1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'd3, 48'd3,  0, 64'd6,  1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'd3, 48'd4,  1, 64'd10, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'd3, 48'd10, 3, 64'd20, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'd0, 48'd100, 3, 64'h0000_7FFF_FFFF_FFFF, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 32'd6, 48'd7,  3, 64'd7,  1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'd4, 48'hFFFF_FFFF_FF9C, 3, 64'hFFFF_8000_0000_0000, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 32'd8, 48'hFFFF_FFFF_FFFB, 3, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'd1, 48'd1,  0, 64'd1,  1'b1};
    vecs[11] = '{1'b1, 1'b0, 32'd2, 48'd1,  0, 64'd1,  1'b1};
    vecs[12] = '{1'b1, 1'b0, 32'd1, 48'd1,  0, 64'd2,  1'b1};
    vecs[13] = '{1'b1, 1'b0, 32'd2, 48'd1,  3, 64'd2,  1'b1};

    wq.delete();
    foreach (vecs[i]) begin
      drive_op(vecs[i].accum, vecs[i].clr, vecs[i].addr, vecs[i].psum);
      repeat (vecs[i].gap) idle_cyc();
    end
    idle_cyc();
    repeat (5) idle_cyc();

    foreach (vecs[i]) begin
      if (wq.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL vec[%0d]_missing: got no write expected data %h", i, vecs[i].exp_data);
      end else begin
        w = wq.pop_front();
        chk($sformatf("vec[%0d]_addr", i), 64'(w.addr), 64'(vecs[i].addr));
        chk($sformatf("vec[%0d]_data", i), w.data, vecs[i].exp_data);
        chk($sformatf("vec[%0d]_ovf", i), 64'(w.ovf), 64'(vecs[i].exp_ovf));
      end
    end
    chk("vec_extra_writes", 64'(wq.size()), 64'd0);
    chk("vec_wr_count", 64'(wr_count), 64'd15);

    // reset lands while two ops are in flight
    drive_op(1'b0, 1'b0, 32'd10, 48'd1);
    drive_op(1'b0, 1'b0, 32'd11, 48'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rstmid_we[%0d]", i), 64'(mem_we), 64'h0);
      if (i == 0) begin
        chk("rstmid_ovf", 64'(ovf), 64'h0);
        chk("rstmid_wr_count", 64'(wr_count), 64'h0);
        chk("rstmid_idle", 64'(idle), 64'h1);
      end
      idle_cyc();
    end

    drive_op(1'b0, 1'b0, 32'd9, 48'd4);
    idle_cyc();
    @(negedge clk);
    chk("post_rst_we_t1", 64'(mem_we), 64'h0);
    idle_cyc();
    @(negedge clk);
    chk("post_rst_we", 64'(mem_we), 64'hFF);
    chk("post_rst_addr", 64'(mem_wr_addr), 64'd9);
    chk("post_rst_data", mem_wr_data, 64'd4);
    idle_cyc();
    @(negedge clk);
    chk("post_rst_wr_count", 64'(wr_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
